// File: rtl/seg7_pkg.sv
// seg7_pkg: shared state encoding and active-low segment codes for the scanned 7-segment display
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'h7F;
endpackage

// File: rtl/seg7_bcd_decode.sv
// seg7_bcd_decode: combinational BCD to active-low 7-segment decoder
//   bcd in  [3:0]  digit value; 10..15 are not BCD
//   seg out [6:0]  {g,f,e,d,c,b,a} active-low; non-BCD values give SEG_OFF
module seg7_bcd_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexes packed BCD digits onto one active-low 7-segment bus
//   clk, rst        clock, asynchronous active-high reset
//   en              scan enable; 0 keeps the display dark
//   bcd_in          packed BCD, nibble k = digit k (digit 0 = units)
//   lz_blank        1 suppresses leading zeros
//   seg_out         {g,f,e,d,c,b,a} active-low
//   dig_sel         active-low digit enables, at most one low
//   frame_done      one-cycle pulse when the last digit slot completes
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  parameter int DIV_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  initial begin
    assert (NUM_DIGITS >= 1 && BLANK_CYC >= 1 && SCAN_DIV > BLANK_CYC && SCAN_DIV <= 2 ** DIV_W)
      else $fatal(1, "seg7_scan_ctrl: illegal parameters");
  end
  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [6:0]              seg_q, seg_d, dec_seg;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d, lead_zero;
  logic                    fd_q, fd_d, last, show, zero_run;
  logic [3:0]              nib;
  assign last = cnt_q == DIV_W'(SCAN_DIV - 1);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    fd_d    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = BLANK;
      idx_d   = '0;
      cnt_d   = '0;
      snap_d  = bcd_in;
    end else begin
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      idx_d   = !last ? idx_q : idx_q == LAST ? '0 : idx_q + 1'b1;
      fd_d    = last && idx_q == LAST;
      snap_d  = fd_d ? bcd_in : snap_q;
      // Each slot starts blank; the blank interval is the first BLANK_CYC counts.
      state_d = cnt_d < DIV_W'(BLANK_CYC) ? BLANK : SHOW;
    end
  end
  // lead_zero[k]: nibbles k..top of the snapshot are all zero.
  always_comb begin
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run && snap_q[4*k +: 4] == 4'd0;
      lead_zero[k] = zero_run;
    end
  end
  // Outputs are computed from the next state so they update on the same edge.
  assign nib = snap_q[idx_d*4 +: 4];
  seg7_bcd_decode u_dec (.bcd(nib), .seg(dec_seg));
  assign show  = state_d == SHOW && !(lz_blank && idx_d != '0 && lead_zero[idx_d]);
  assign seg_d = show ? dec_seg : SEG_OFF;
  assign dig_d = show ? ~(NUM_DIGITS'(1) << idx_d) : '1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      seg_q   <= SEG_OFF;
      dig_q   <= '1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      fd_q    <= fd_d;
    end
  end
  assign seg_out    = seg_q;
  assign dig_sel    = dig_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: self-checking bench for seg7_scan_ctrl with a per-cycle expectation queue
module tb_seg7_scan_ctrl;
  localparam int ND = 3, SD = 8, BC = 2;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S9 = 7'b0010000, OFF = 7'h7F;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, lz_blank = 1'b0;
  logic [11:0] bcd_in = 12'h000;
  logic [6:0] seg_out;
  logic [2:0] dig_sel;
  logic frame_done;
  int tests = 0, failed = 0;
  typedef struct packed {logic [6:0] seg; logic [2:0] dig; logic fd;} exp_t;
  typedef struct packed {logic [11:0] bcd; logic lz; logic [2:0][6:0] seg; logic [2:0] show;} vec_t;
  exp_t q[$];
  vec_t vecs[7];
  seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in), .lz_blank(lz_blank),
    .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  logic [2:0] prev_dig = 3'b111;
  int dark_run = 100;
  always @(posedge clk) begin
    exp_t e;
    #1;
    tests++;
    if ($countones(~dig_sel) > 1) begin
      failed++;
      $display("FAIL onehot dig_sel=%b required at most one low", dig_sel);
    end
    if (rst) dark_run = 100;
    else if (dig_sel == 3'b111) dark_run++;
    else begin
      tests++;
      if ((prev_dig != 3'b111 && dig_sel != prev_dig) || (prev_dig == 3'b111 && dark_run < BC)) begin
        failed++;
        $display("FAIL gap dig_sel=%b after %0d dark cycles, required >= %0d", dig_sel, dark_run, BC);
      end
      dark_run = 0;
    end
    prev_dig = dig_sel;
    if (q.size() != 0) begin
      e = q.pop_front();
      tests++;
      if ({seg_out, dig_sel, frame_done} !== e) begin
        failed++;
        $display("FAIL cyc @%0t got seg=%b dig=%b fd=%b required seg=%b dig=%b fd=%b",
                 $time, seg_out, dig_sel, frame_done, e.seg, e.dig, e.fd);
      end
    end
  end
  task automatic step(input logic [6:0] s, input logic [2:0] d, input logic f);
    q.push_back('{seg: s, dig: d, fd: f});
    @(negedge clk);
  endtask
  task automatic push_slot(input int d, input logic [6:0] s, input logic sh, input logic fd);
    for (int i = 0; i < BC; i++) step(OFF, 3'b111, fd && i == 0);
    for (int i = 0; i < SD - BC; i++) step(sh ? s : OFF, sh ? ~(3'b001 << d) : 3'b111, 1'b0);
  endtask
  task automatic push_frame(input logic [2:0][6:0] s, input logic [2:0] sh, input logic fd);
    for (int d = 0; d < ND; d++) push_slot(d, s[d], sh[d], fd && d == 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL drain %0d expectations left, required 0", q.size());
      q.delete();
    end
  endtask
  task automatic chk_dark(input string name);
    tests++;
    if ({seg_out, dig_sel, frame_done} !== {OFF, 3'b111, 1'b0}) begin
      failed++;
      $display("FAIL %s got seg=%b dig=%b fd=%b required seg=1111111 dig=111 fd=0",
               name, seg_out, dig_sel, frame_done);
    end
  endtask
  task automatic start(input logic [11:0] b, input logic lz);
    @(negedge clk);
    rst = 1'b1;
    #1 chk_dark("reset");
    bcd_in = b;
    lz_blank = lz;
    en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    vecs[0] = '{12'h149, 1'b0, {S1, S4, S9}, 3'b111};
    vecs[1] = '{12'h005, 1'b1, {OFF, OFF, S5}, 3'b001};
    vecs[2] = '{12'h000, 1'b1, {OFF, OFF, S0}, 3'b001};
    vecs[3] = '{12'h005, 1'b0, {S0, S0, S5}, 3'b111};
    vecs[4] = '{12'h1A3, 1'b0, {S1, OFF, S3}, 3'b111};
    vecs[5] = '{12'h050, 1'b1, {OFF, S5, S0}, 3'b011};
    vecs[6] = '{12'h100, 1'b1, {S1, S0, S0}, 3'b111};
    repeat (3) @(negedge clk);
    chk_dark("reset_en");
    for (int v = 0; v < 7; v++) begin
      start(vecs[v].bcd, vecs[v].lz);
      push_frame(vecs[v].seg, vecs[v].show, 1'b0);
      push_frame(vecs[v].seg, vecs[v].show, 1'b1);
      drain();
    end
    start(12'h149, 1'b0);
    step(OFF, 3'b111, 1'b0);
    step(OFF, 3'b111, 1'b0);
    repeat (3) step(S9, 3'b110, 1'b0);
    drain();
    #2 rst = 1'b1;
    #1 chk_dark("async_rst");
    start(12'h149, 1'b0);
    push_slot(0, S9, 1'b1, 1'b0);
    step(OFF, 3'b111, 1'b0);
    step(OFF, 3'b111, 1'b0);
    repeat (2) step(S4, 3'b101, 1'b0);
    bcd_in = 12'h023;
    repeat (4) step(S4, 3'b101, 1'b0);
    push_slot(2, S1, 1'b1, 1'b0);
    push_frame({S0, S2, S3}, 3'b111, 1'b1);
    drain();
    start(12'h149, 1'b0);
    push_slot(0, S9, 1'b1, 1'b0);
    step(OFF, 3'b111, 1'b0);
    step(OFF, 3'b111, 1'b0);
    repeat (2) step(S4, 3'b101, 1'b0);
    en = 1'b0;
    repeat (3) step(OFF, 3'b111, 1'b0);
    bcd_in = 12'h023;
    en = 1'b1;
    push_frame({S0, S2, S3}, 3'b111, 1'b0);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
